// File: rtl/aes_pkg.sv
// Shared AES constants, state type and byte/word helpers for the inverse key schedule.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_LAST = 8'h36;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Inverse of GF(2^8) doubling: walks the round constants downwards.
  function automatic logic [7:0] inv_xtime(logic [7:0] b);
    if (b[0]) begin
      return ((b ^ 8'h1b) >> 1) | 8'h80;
    end
    return b >> 1;
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel forward S-box lookups on a 32-bit word; purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key-schedule walker: emits round keys 10 down to 0 from the last round key.
// Define AES_INV_KS_RCON_ROM_EN to derive rcon from a round-indexed lookup instead of a register.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] key_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  state_e       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon;

  logic         load, step;
  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3, sub_p3;

  assign load = (state_q == StIdle) && in_valid && !abort;
  assign step = (state_q == StRun) && rk_ready && !abort && (round_q != 4'd0);

  assign k0 = key_q[0:31];
  assign k1 = key_q[32:63];
  assign k2 = key_q[64:95];
  assign k3 = key_q[96:127];

  assign p3     = k3 ^ k2;
  assign p2     = k2 ^ k1;
  assign p1     = k1 ^ k0;
  assign rot_p3 = rot_word(p3);
  assign p0     = k0 ^ sub_p3 ^ {rcon, 24'h0};

  aes_sub_word u_sub_word (
    .word_i (rot_p3),
    .word_o (sub_p3)
  );

`ifdef AES_INV_KS_RCON_ROM_EN
  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end
`else
  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load) begin
      rcon_d = RCON_LAST;
    end else if (step) begin
      rcon_d = inv_xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= 8'h00;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          key_d   = key_in;
          round_d = 4'(AES_NR);
          state_d = StRun;
        end
      end
      StRun: begin
        // abort wins over a simultaneous output handshake
        if (abort) begin
          state_d = StIdle;
        end else if (rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign rk_valid = (state_q == StRun);
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign rk_last  = rk_valid && (round_q == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched; compile with and without AES_INV_KS_RCON_ROM_EN.
module tb_aes_inv_key_sched;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] key_in = '0;
  logic         abort = 1'b0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_in   (key_in),
    .abort    (abort),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_last  (rk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] fwd_rcon(int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b;  10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Forward FIPS-197 expansion from the cipher key into exp_rk[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
        t = t ^ {fwd_rcon(i / 4), 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Present a key once in_ready is seen; returns at the negedge where round 10 should show.
  task automatic start_key(input logic [127:0] k);
    int i;
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    in_valid = 1'b1;
    key_in   = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || rk_valid !== 1'b0 || rk_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%b valid=%b last=%b want 1 0 0",
               in_ready, rk_valid, rk_last);
    end
    n_checks++;
    if (rk_out !== 128'h0 || rk_round !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: got out=%h round=%0d want 0 0", rk_out, rk_round);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    start_key(FIPS_K10);
    rk_ready = 1'b1;
    n_checks++;
    if (rk_valid !== 1'b1 || rk_out !== FIPS_K10) begin
      n_fail++;
      $display("FAIL fips_r10: got valid=%b out=%h want 1 %h", rk_valid, rk_out, FIPS_K10);
    end
    for (int r = 10; r >= 0; r--) begin
      n_checks++;
      if (rk_round !== 4'(r)) begin
        n_fail++;
        $display("FAIL fips_round: got %0d want %0d", rk_round, r);
      end
      if (r == 9) begin
        n_checks++;
        if (rk_out !== 128'hac7766f319fadc2128d12941575c006e) begin
          n_fail++;
          $display("FAIL fips_r9: got %h want ac7766f319fadc2128d12941575c006e", rk_out);
        end
      end
      if (r == 1) begin
        n_checks++;
        if (rk_out !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          n_fail++;
          $display("FAIL fips_r1: got %h want a0fafe1788542cb123a339392a6c7605", rk_out);
        end
      end
      if (r == 0) begin
        n_checks++;
        if (rk_out !== FIPS_K0 || rk_last !== 1'b1) begin
          n_fail++;
          $display("FAIL fips_r0: got %h last=%b want %h last=1", rk_out, rk_last, FIPS_K0);
        end
      end else begin
        n_checks++;
        if (rk_last !== 1'b0) begin
          n_fail++;
          $display("FAIL fips_last_early: got %b want 0 at round %0d", rk_last, r);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_done: got ready=%b valid=%b want 1 0", in_ready, rk_valid);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx, cyc;
    logic stalled;
    logic [127:0] held_out;
    logic [3:0] held_round;
    expand(FIPS_K0);
    start_key(exp_rk[10]);
    idx = 10;
    cyc = 0;
    stalled = 1'b0;
    held_out = '0;
    held_round = '0;
    while (idx >= 0) begin
      if (cyc >= 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL bp_timeout: got round %0d want walk complete", idx);
        break;
      end
      n_checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(idx) || rk_out !== exp_rk[idx]) begin
        n_fail++;
        $display("FAIL bp_seq: got v=%b r=%0d %h want v=1 r=%0d %h",
                 rk_valid, rk_round, rk_out, idx, exp_rk[idx]);
      end
      if (stalled) begin
        n_checks++;
        if (rk_out !== held_out || rk_round !== held_round) begin
          n_fail++;
          $display("FAIL bp_hold: got r=%0d %h want r=%0d %h",
                   rk_round, rk_out, held_round, held_out);
        end
      end
      rk_ready   = 1'($urandom_range(0, 1));
      stalled    = !rk_ready;
      held_out   = rk_out;
      held_round = rk_round;
      if (rk_ready) idx--;
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    expand(FIPS_K0);
    start_key(exp_rk[10]);
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_round != 4'd5 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rk_round !== 4'd5 || rk_out !== exp_rk[5]) begin
      n_fail++;
      $display("FAIL abort_reach5: got r=%0d %h want r=5 %h", rk_round, rk_out, exp_rk[5]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_run: got valid=%b ready=%b want 0 1", rk_valid, in_ready);
    end
    abort    = 1'b1;
    in_valid = 1'b1;
    key_in   = FIPS_K10;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: got valid=%b ready=%b want 0 1", rk_valid, in_ready);
    end
    start_key(FIPS_K10);
    n_checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_out !== FIPS_K10) begin
      n_fail++;
      $display("FAIL abort_restart: got v=%b r=%0d %h want v=1 r=10 %h",
               rk_valid, rk_round, rk_out, FIPS_K10);
    end
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic test_reset_midwalk();
    int pulses;
    start_key(FIPS_K10);
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 ||
        rk_round !== 4'd0 || rk_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got ready=%b valid=%b out=%h r=%0d last=%b want 1 0 0 0 0",
               in_ready, rk_valid, rk_out, rk_round, rk_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (rk_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got %0d valid cycles want 0", pulses);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_in_valid_hold();
    logic [127:0] key_b;
    int i;
    key_b = 128'h000102030405060708090a0b0c0d0e0f;
    expand(FIPS_K0);
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    in_valid = 1'b1;
    key_in   = exp_rk[10];
    rk_ready = 1'b1;
    @(negedge clk);
    key_in = key_b;
    for (int r = 10; r >= 0; r--) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        n_fail++;
        $display("FAIL hold_seq: got v=%b r=%0d %h want v=1 r=%0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_gap: got ready=%b valid=%b want 1 0", in_ready, rk_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_out !== key_b) begin
      n_fail++;
      $display("FAIL hold_second: got v=%b r=%0d %h want v=1 r=10 %h",
               rk_valid, rk_round, rk_out, key_b);
    end
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] k;
    repeat (100) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(k);
      start_key(exp_rk[10]);
      rk_ready = 1'b1;
      for (int r = 10; r >= 0; r--) begin
        n_checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
          n_fail++;
          $display("FAIL rand_seq: got v=%b r=%0d %h want v=1 r=%0d %h",
                   rk_valid, rk_round, rk_out, r, exp_rk[r]);
        end
        @(negedge clk);
      end
      rk_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_abort();
    test_reset_midwalk();
    test_in_valid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Reverse AES-128 key-schedule walker for the decryption datapath. It accepts the final (round-10) round key and emits round keys 10, 9, …, 0, one per output handshake. Each step applies the inverse key-expansion recurrence with internally generated round constants in descending order (0x36, 0x1b, 0x80 … 0x01). It sits between key storage and the inverse-cipher round logic, so the decryptor never needs a full 11-key buffer.

## Interface
- No parameters; fixed to AES-128, 4 words, 10 rounds.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  last round key on key_in is valid.
- in_ready  output  1  block idle, can accept a key.
- key_in  input  [0:127]  round-10 key, word 0 = bits [0:31], byte 0 = bits [0:7].
- abort  input  1  synchronous cancel of the current walk.
- rk_valid  output  1  rk_out holds a valid round key.
- rk_ready  input  1  consumer accepts rk_out.
- rk_out  output  [0:127]  current round key, same ordering as key_in.
- rk_round  output  4  round index of rk_out (10 down to 0).
- rk_last  output  1  high with rk_valid when rk_round == 0.

## Operation
- States: IDLE, RUN.
- IDLE: in_ready = 1. On in_valid, load key_in into the key register, set round = 10 and rcon = 0x36, then go to RUN.
- RUN: rk_valid = 1, rk_out = key register, rk_round = round.
- Output handshake in RUN (rk_valid && rk_ready):
  - If round == 0: go to IDLE.
  - Otherwise, with current words k0..k3, compute previous words p3 = k3^k2, p2 = k2^k1, p1 = k1^k0, p0 = k0 ^ SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - Then round decrements by 1 and rcon <= inv_xtime(rcon).
- inv_xtime(b): if b[bit weight 1] == 1, result = ((b ^ 0x1b) >> 1) | 0x80; otherwise result = b >> 1. All arithmetic is 8-bit, no carry out.
- rcon in use for round r equals the forward constant of round r.
- abort: in any state, next state is IDLE and rk_valid drops next cycle. abort has priority over a simultaneous output handshake and over in_valid in IDLE.
- rk_valid && !rk_ready: rk_out, rk_round and rk_last are held stable.
- Reset mid-walk discards everything; no partial output follows.

## Timing
- Reset values: in_ready = 1, rk_valid = 0, rk_out = 0, rk_round = 0, rk_last = 0, state IDLE, rcon = 0.
- Input accepted at edge N gives rk_valid = 1 (round 10) from cycle N+1.
- With rk_ready held high, one key is emitted per cycle. A full walk takes 11 cycles, and in_ready returns the cycle after the round-0 handshake.
- in_ready is low throughout RUN; there is no back-to-back overlap of walks.
- All outputs are registered except rk_last, which is decoded from the registered round.

## Configuration
- AES_INV_KS_RCON_ROM_EN defined: rcon comes from a 10-entry case lookup indexed by round (1→0x01 … 8→0x80, 9→0x1b, 10→0x36, else 0x00). The rcon register is removed.
- Undefined: rcon is the register updated by inv_xtime as above.
- Port list and cycle behaviour are identical in both builds. The bench runs both.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry forward S-box constant array;
  - constants AES_NR = 10 and RCON_LAST = 8'h36;
  - the state enum;
  - the inv_xtime and rot_word functions.
- One sub-module, aes_sub_word: four parallel S-box byte lookups, 32 in / 32 out, purely combinational.

## Test plan
- FIPS-197 A.1: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready held high → round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last = 1.
- Backpressure: toggle rk_ready randomly → rk_out and rk_round stable while stalled; the sequence is identical to the unstalled run.
- abort asserted at round 5, concurrently with rk_ready → next cycle rk_valid = 0 and in_ready = 1; a new key is then accepted and restarts at round 10.
- rst_n pulsed low mid-walk → all outputs at reset values immediately; there are no further rk_valid pulses.
- in_valid held high during RUN → ignored. The second key is taken only after round 0 is consumed, and its round 10 appears the following cycle.
- Both builds of AES_INV_KS_RCON_ROM_EN → bit-identical rk_out sequences for 100 random keys, checked against a forward-expansion model.
